// File: rtl/ins_counter_n_pkg.sv
// Shared control definitions for the NW datapath counters: counting modes
// and the counter state encoding.
package nw_ctrl_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic {
    COUNT = 1'b0,
    HOLD  = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/ins_counter_n_if.sv
// Control/status bundle between a counter user (master) and the event counter
// (slave); clock and reset travel separately.
interface ins_counter_n_if #(
  parameter int CNT_W  = 8,
  parameter int WRAP_W = 8
);

  logic              clr;
  logic              en_ins;
  logic              load_term;
  logic [CNT_W-1:0]  term_in;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  term;
  logic              hit;
  logic              done;
  logic [WRAP_W-1:0] rounds;
  logic              term_err;

  modport master (
    output clr, en_ins, load_term, term_in,
    input  count, term, hit, done, rounds, term_err
  );

  modport slave (
    input  clr, en_ins, load_term, term_in,
    output count, term, hit, done, rounds, term_err
  );

endinterface

// File: rtl/ins_counter_n.sv
// Event counter with programmable terminal value, wrap or saturate behaviour,
// a round counter and rejection of zero terminal loads.
module ins_counter_n
  import nw_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int TERM_RST = 4,
  parameter int SAT_MODE = 0,
  parameter int WRAP_W   = 8
) (
  input logic            clk,
  input logic            rst,
  ins_counter_n_if.slave bus
);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WRAP_W-1:0] RND_ONE   = WRAP_W'(1);
  localparam logic [CNT_W-1:0]  TERM_INIT = CNT_W'(TERM_RST);

  cnt_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  term_q, term_d;
  logic [WRAP_W-1:0] rounds_q, rounds_d;
  logic              done_q, done_d;
  logic              term_err_q, term_err_d;

  logic loadAccept;
  logic loadReject;
  logic atTerm;
  logic event_hit;

  assign loadAccept = bus.load_term && (bus.term_in != '0);
  assign loadReject = bus.load_term && (bus.term_in == '0);
  // Compared in CNT_W bits so that term=1 makes every enabled cycle terminal.
  assign atTerm     = (count_q == (term_q - CNT_ONE));

  assign event_hit = !rst && !bus.clr && !loadAccept && (state_q == COUNT)
                     && bus.en_ins && atTerm;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    term_d     = term_q;
    rounds_d   = rounds_q;
    done_d     = done_q;
    term_err_d = 1'b0;
    if (bus.clr) begin
      state_d  = COUNT;
      count_d  = '0;
      rounds_d = '0;
      done_d   = 1'b0;
    end else if (loadAccept) begin
      state_d = COUNT;
      term_d  = bus.term_in;
      count_d = '0;
      done_d  = 1'b0;
    end else begin
      term_err_d = loadReject;
      if (event_hit) begin
        rounds_d = rounds_q + RND_ONE;
        if (SAT_MODE == MODE_SAT) begin
          done_d  = 1'b1;
          state_d = HOLD;
        end else begin
          count_d = '0;
        end
      end else if ((state_q == COUNT) && bus.en_ins) begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COUNT;
      count_q    <= '0;
      term_q     <= TERM_INIT;
      rounds_q   <= '0;
      done_q     <= 1'b0;
      term_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      term_q     <= term_d;
      rounds_q   <= rounds_d;
      done_q     <= done_d;
      term_err_q <= term_err_d;
    end
  end

  assign bus.hit      = event_hit;
  assign bus.count    = count_q;
  assign bus.term     = term_q;
  assign bus.rounds   = rounds_q;
  assign bus.done     = done_q;
  assign bus.term_err = term_err_q;

endmodule

// File: tb/tb_ins_counter_n.sv
// Drives a wrap-mode and a saturate-mode counter with identical stimulus and
// compares both against a behavioural model through an expectation queue.
module tb_ins_counter_n;

  typedef struct {
    int         dut;
    logic [7:0] count;
    logic [7:0] term;
    logic       done;
    logic [7:0] rounds;
    logic       term_err;
  } exp_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  exp_t expQ[$];

  logic [7:0] mCount[2];
  logic [7:0] mTerm[2];
  logic [7:0] mRounds[2];
  logic       mDone[2];
  logic       mHold[2];
  logic       mErr[2];

  ins_counter_n_if #(.CNT_W(8), .WRAP_W(8)) ifW ();
  ins_counter_n_if #(.CNT_W(8), .WRAP_W(8)) ifS ();

  ins_counter_n #(.CNT_W(8), .TERM_RST(4), .SAT_MODE(0), .WRAP_W(8)) dutW (
    .clk(clk), .rst(rst), .bus(ifW)
  );
  ins_counter_n #(.CNT_W(8), .TERM_RST(4), .SAT_MODE(1), .WRAP_W(8)) dutS (
    .clk(clk), .rst(rst), .bus(ifS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic checkOutput();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (expQ.size() == 0) begin
        checkValue("queueEmpty", 32'd0, 32'd1);
      end else begin
        e = expQ.pop_front();
        if (e.dut == 0) begin
          checkValue("W.count", ifW.count, e.count);
          checkValue("W.term", ifW.term, e.term);
          checkValue("W.done", ifW.done, e.done);
          checkValue("W.rounds", ifW.rounds, e.rounds);
          checkValue("W.term_err", ifW.term_err, e.term_err);
        end else begin
          checkValue("S.count", ifS.count, e.count);
          checkValue("S.term", ifS.term, e.term);
          checkValue("S.done", ifS.done, e.done);
          checkValue("S.rounds", ifS.rounds, e.rounds);
          checkValue("S.term_err", ifS.term_err, e.term_err);
        end
      end
    end
  endtask

  // One clock of stimulus: hit is judged mid-cycle, registers after the edge.
  task automatic applyStimulus(input logic r, input logic c, input logic e,
                               input logic l, input logic [7:0] t);
    logic expHit[2];
    exp_t x;
    rst = r;
    ifW.clr = c; ifW.en_ins = e; ifW.load_term = l; ifW.term_in = t;
    ifS.clr = c; ifS.en_ins = e; ifS.load_term = l; ifS.term_in = t;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      expHit[m] = !r && !c && !(l && t != 0) && !mHold[m] && e
                  && (int'(mCount[m]) + 1 == int'(mTerm[m]));
    end
    checkValue("W.hit", ifW.hit, expHit[0]);
    checkValue("S.hit", ifS.hit, expHit[1]);
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        mCount[m] = 0; mTerm[m] = 4; mRounds[m] = 0;
        mDone[m] = 0; mHold[m] = 0; mErr[m] = 0;
      end else if (c) begin
        mCount[m] = 0; mRounds[m] = 0; mDone[m] = 0; mHold[m] = 0; mErr[m] = 0;
      end else if (l && t != 0) begin
        mTerm[m] = t; mCount[m] = 0; mDone[m] = 0; mHold[m] = 0; mErr[m] = 0;
      end else begin
        mErr[m] = l;
        if (expHit[m]) begin
          mRounds[m] = 8'((int'(mRounds[m]) + 1) % 256);
          if (m == 1) begin
            mDone[m] = 1; mHold[m] = 1;
          end else begin
            mCount[m] = 0;
          end
        end else if (e && !mHold[m]) begin
          mCount[m] = mCount[m] + 8'd1;
        end
      end
      x.dut = m; x.count = mCount[m]; x.term = mTerm[m]; x.done = mDone[m];
      x.rounds = mRounds[m]; x.term_err = mErr[m];
      expQ.push_back(x);
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int m = 0; m < 2; m++) begin
      mCount[m] = 0; mTerm[m] = 4; mRounds[m] = 0;
      mDone[m] = 0; mHold[m] = 0; mErr[m] = 0;
    end
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);

    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 0, 0);
    checkValue("planWrapRounds", ifW.rounds, 2);
    checkValue("planWrapCount", ifW.count, 1);
    checkValue("planSatCount", ifS.count, 3);
    checkValue("planSatDone", ifS.done, 1);

    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkValue("planRejectTerm", ifW.term, 4);
    checkValue("planRejectCount", ifW.count, 3);
    applyStimulus(0, 0, 0, 0, 0);
    checkValue("planErrPulseEnd", ifW.term_err, 0);

    applyStimulus(0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
    checkValue("planTerm1Rounds", ifW.rounds, 3);

    applyStimulus(0, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkValue("planClrRounds", ifW.rounds, 0);

    for (int i = 0; i < 22; i++) applyStimulus(0, 0, 1, 0, 0);
    checkValue("planPreRstRounds", ifW.rounds, 5);
    checkValue("planPreRstCount", ifW.count, 2);
    applyStimulus(0, 0, 1, 1, 8'd255);
    applyStimulus(1, 0, 1, 0, 0);

    for (int i = 0; i < 120; i++) begin
      applyStimulus(($urandom % 40) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
                    ($urandom % 8) == 0, 8'($urandom_range(0, 5)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ins_counter_n.md
# ins_counter_n

Parametrised event counter for the RAM signal-management path of the NW datapath. Counts `en_ins` strobes up to a run-time programmable terminal value and flags the terminal event. Supports wrap mode (free-running modulo counter) and saturate mode (stop and hold `done` until cleared). Keeps a count of completed rounds and rejects illegal terminal loads.

## Interface
- `CNT_W`, 8: width of `count` and `term`.
- `TERM_RST`, 4: terminal value after reset; must satisfy 1 ≤ TERM_RST ≤ 2^CNT_W−1.
- `SAT_MODE`, 0: 0 = wrap, 1 = saturate.
- `WRAP_W`, 8: width of the `rounds` counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous clear of `count`, `rounds` and `done`; `term` is kept.
- `en_ins`  in  1  count-enable strobe, one event per cycle it is high.
- `load_term`  in  1  load `term_in` as the new terminal value.
- `term_in`  in  CNT_W  new terminal value.
- `count`  out  CNT_W  registered current count.
- `term`  out  CNT_W  registered active terminal value.
- `hit`  out  1  combinational; high in the cycle the terminal event is accepted.
- `done`  out  1  registered, sticky in saturate mode; always 0 in wrap mode.
- `rounds`  out  WRAP_W  registered number of terminal events since reset or `clr`; wraps modulo 2^WRAP_W.
- `term_err`  out  1  registered one-cycle pulse when a `load_term` is rejected.

## Operation
- Reset values: `count`=0, `term`=TERM_RST, `done`=0, `rounds`=0, `term_err`=0, state=COUNT. `hit`=0 while `rst` is high.
- FSM states: COUNT and HOLD. HOLD is reachable only when SAT_MODE=1.
- Priority, highest first: `rst` > `clr` > `load_term` > `en_ins`.

COUNT state, `en_ins`=1:
- `count` < `term`−1: `count` ← `count`+1, `hit`=0.
- `count` = `term`−1: `hit`=1 and `rounds` ← `rounds`+1.
  - Wrap mode: `count` ← 0, stay in COUNT.
  - Saturate mode: `count` holds at `term`−1, `done` ← 1, go to HOLD.

HOLD state:
- `en_ins` is ignored: `hit`=0 and `count` holds.
- Exit only through `clr`, `rst` or an accepted `load_term`; all three return to COUNT with `count`=0 and `done`=0.

`clr`:
- `count` ← 0, `rounds` ← 0, `done` ← 0, next state COUNT.
- `hit` is forced to 0 in the same cycle, even if `en_ins` is high.

`load_term`:
- `term_in` ≠ 0: `term` ← `term_in`, `count` ← 0, `done` ← 0, next state COUNT. A coincident `en_ins` is dropped and `hit`=0.
- `term_in` = 0: rejected. `term` is unchanged, `term_err` pulses next cycle, and `en_ins` is processed normally.

Arithmetic:
- Unsigned throughout.
- The `count`=`term`−1 comparison uses CNT_W bits, so `term`=1 makes every enabled cycle a hit.
- `count` never exceeds `term`−1.

## Timing
- `hit` has zero latency: it is a combinational function of `en_ins`, `count`, `term`, state, `clr`, `load_term`, `term_in` and `rst`.
- `count`, `rounds` and `done` reflect an event on the following rising edge.
- `term_err` is asserted exactly one cycle after the rejected load.
- Back-to-back `en_ins` is legal: one event per cycle, no bubbles.
- In wrap mode `hit` recurs every `term` enabled cycles.
- Reset mid-count takes effect on the next edge; no partial state survives.

## Structure
- Shared package `nw_ctrl_pkg` holds:
  - mode constants `MODE_WRAP`=0 and `MODE_SAT`=1;
  - the state encoding typedef (COUNT=0, HOLD=1).
- Single module, no sub-module.
- Separate blocks for:
  - next-state/next-count combinational logic;
  - one synchronous register block;
  - the combinational `hit` decode.

## Test plan
- Reset, SAT_MODE=0, TERM_RST=4, `en_ins` held high 9 cycles:
  - `hit` high in cycles 4 and 8;
  - `count` sequence 1,2,3,0,1,2,3,0,1;
  - `rounds`=2.
- SAT_MODE=1, `en_ins` high 6 cycles:
  - `hit` only in cycle 4;
  - `count` holds at 3 and `done`=1 from cycle 5;
  - after `clr`: `count`=0, `done`=0, counting resumes.
- `load_term` with `term_in`=0 while `count`=2, `en_ins`=1:
  - `term` stays 4, `count`→3, `term_err` pulses one cycle later.
- `load_term` with `term_in`=1, then `en_ins` high 3 cycles: `hit` every cycle, `count` stays 0, `rounds`=3.
- `clr` and `en_ins` together with `count`=3: `hit`=0, `count`=0, `rounds`=0.
- `rst` asserted with `count`=2 and `rounds`=5: next cycle all outputs at reset values and `term`=TERM_RST.
